cpu_sequencer: RTL and testbench

Multi-cycle control unit for the 8-bit/4-bit CPU. It owns the program counter, instruction register, 4-bit accumulator and flags, and sequences each instruction through FETCH, DECODE and EXECUTE. Instructions are fetched from the shared 256x8 memory through a req/ack read port. The block sits between the instruction memory and the combinational ALU sub-module, and replaces free-running PC increment with handshaked, haltable execution.

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/cpu_sequencer_if.sv | 17 +
 rtl/cpu_alu.sv | 70 +++++++
 rtl/cpu_sequencer.sv | 155 +++++++++++++++
 tb/tb_cpu_sequencer.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants for the 8-bit address / 4-bit data CPU.
// Holds field widths, opcode values and the sequencer state encoding used by
// cpu_sequencer_if, cpu_alu and cpu_sequencer.
package cpu_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 4;
  localparam int OPC_W  = 4;

  // Opcodes (instruction byte [7:4])
  localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
  localparam logic [OPC_W-1:0] OP_LDI = 4'h1;
  localparam logic [OPC_W-1:0] OP_ADD = 4'h2;
  localparam logic [OPC_W-1:0] OP_SUB = 4'h3;
  localparam logic [OPC_W-1:0] OP_AND = 4'h4;
  localparam logic [OPC_W-1:0] OP_OR  = 4'h5;
  localparam logic [OPC_W-1:0] OP_XOR = 4'h6;
  localparam logic [OPC_W-1:0] OP_JMP = 4'h7;
  localparam logic [OPC_W-1:0] OP_JZ  = 4'h8;
  localparam logic [OPC_W-1:0] OP_JC  = 4'h9;
  localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

  // Sequencer states
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_DECODE  = 3'd2;
  localparam logic [2:0] S_EXECUTE = 3'd3;
  localparam logic [2:0] S_HALT    = 3'd4;
  localparam logic [2:0] S_FAULT   = 3'd5;

endpackage

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: instruction-memory read port (req/ack).
//   mem_req   : read request, held while the requester waits
//   mem_addr  : read address, stable while mem_req is high
//   mem_ack   : read accepted, mem_rdata valid in the same cycle
//   mem_rdata : instruction byte
// master = sequencer side, slave = memory side.
interface cpu_sequencer_if;
  import cpu_pkg::*;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/cpu_alu.sv
// cpu_alu: combinational accumulator datapath.
//   op_i         : opcode
//   acc_i        : current accumulator
//   opd_i        : 4-bit immediate operand
//   carry_i      : current carry, passed through when the op leaves it alone
//   acc_o        : new accumulator
//   carry_o      : new carry/borrow
//   zero_o       : new accumulator is zero
//   writes_acc_o : op updates acc and flags
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [OPC_W-1:0]  op_i,
  input  logic [DATA_W-1:0] acc_i,
  input  logic [DATA_W-1:0] opd_i,
  input  logic              carry_i,
  output logic [DATA_W-1:0] acc_o,
  output logic              carry_o,
  output logic              zero_o,
  output logic              writes_acc_o
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  // Extra MSB carries the carry-out of ADD and the borrow of SUB.
  assign sum  = {1'b0, acc_i} + {1'b0, opd_i};
  assign diff = {1'b0, acc_i} - {1'b0, opd_i};

  always_comb begin
    acc_o        = acc_i;
    carry_o      = carry_i;
    writes_acc_o = 1'b0;
    case (op_i)
      OP_LDI: begin
        acc_o        = opd_i;
        writes_acc_o = 1'b1;
      end
      OP_ADD: begin
        {carry_o, acc_o} = sum;
        writes_acc_o     = 1'b1;
      end
      OP_SUB: begin
        {carry_o, acc_o} = diff;
        writes_acc_o     = 1'b1;
      end
      OP_AND: begin
        acc_o        = acc_i & opd_i;
        carry_o      = 1'b0;
        writes_acc_o = 1'b1;
      end
      OP_OR: begin
        acc_o        = acc_i | opd_i;
        carry_o      = 1'b0;
        writes_acc_o = 1'b1;
      end
      OP_XOR: begin
        acc_o        = acc_i ^ opd_i;
        carry_o      = 1'b0;
        writes_acc_o = 1'b1;
      end
      default: begin
        acc_o = acc_i;
      end
    endcase
  end

  assign zero_o = (acc_o == '0);

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle FETCH/DECODE/EXECUTE control unit.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   start      : (re)start execution at pc 0 from IDLE, HALT or FAULT
//   mem        : instruction read port (master side)
//   result     : accumulator
//   pc         : program counter (also the fetch address)
//   zero/carry : flags
//   retire     : high during the EXECUTE cycle of every instruction
//   busy       : FETCH/DECODE/EXECUTE
//   halted     : HALT state
//   fault      : FAULT state (fetch timed out)
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  cpu_sequencer_if.master   mem,
  output logic [DATA_W-1:0] result,
  output logic [ADDR_W-1:0] pc,
  output logic              zero,
  output logic              carry,
  output logic              retire,
  output logic              busy,
  output logic              halted,
  output logic              fault
);

  // Value of the wait counter during the last FETCH cycle allowed without ack.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        ir_q, ir_d;
  logic [OPC_W-1:0]  op_q, op_d;
  logic [DATA_W-1:0] opd_q, opd_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              zero_q, zero_d;
  logic              carry_q, carry_d;
  logic [7:0]        wait_q, wait_d;

  logic [DATA_W-1:0] alu_acc;
  logic              alu_carry;
  logic              alu_zero;
  logic              alu_writes;

  cpu_alu u_alu (
    .op_i         (op_q),
    .acc_i        (acc_q),
    .opd_i        (opd_q),
    .carry_i      (carry_q),
    .acc_o        (alu_acc),
    .carry_o      (alu_carry),
    .zero_o       (alu_zero),
    .writes_acc_o (alu_writes)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    op_d    = op_q;
    opd_d   = opd_q;
    acc_d   = acc_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    wait_d  = wait_q;
    case (state_q)
      S_IDLE, S_HALT, S_FAULT: begin
        if (start) begin
          pc_d    = '0;
          acc_d   = '0;
          zero_d  = 1'b1;
          carry_d = 1'b0;
          wait_d  = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        // An ack in the final allowed cycle still wins over the timeout.
        if (mem.mem_ack) begin
          ir_d    = mem.mem_rdata;
          pc_d    = pc_q + 8'd1;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DECODE: begin
        op_d    = ir_q[7:4];
        opd_d   = ir_q[3:0];
        state_d = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (alu_writes) begin
          acc_d   = alu_acc;
          zero_d  = alu_zero;
          carry_d = alu_carry;
        end
        // Taken jumps overwrite the already-incremented pc.
        if ((op_q == OP_JMP) ||
            (op_q == OP_JZ && zero_q) ||
            (op_q == OP_JC && carry_q)) begin
          pc_d = {4'h0, opd_q};
        end
        wait_d  = '0;
        state_d = (op_q == OP_HLT) ? S_HALT : S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      op_q    <= '0;
      opd_q   <= '0;
      acc_q   <= '0;
      zero_q  <= 1'b1;
      carry_q <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      op_q    <= op_d;
      opd_q   <= opd_d;
      acc_q   <= acc_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      wait_q  <= wait_d;
    end
  end

  // Outputs come straight from registers or the state decode, so mem_req
  // has no path from mem_ack and drops as soon as reset clears the state.
  assign mem.mem_req  = (state_q == S_FETCH);
  assign mem.mem_addr = pc_q;
  assign result       = acc_q;
  assign pc           = pc_q;
  assign zero         = zero_q;
  assign carry        = carry_q;
  assign retire       = (state_q == S_EXECUTE);
  assign busy         = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                        (state_q == S_EXECUTE);
  assign halted       = (state_q == S_HALT);
  assign fault        = (state_q == S_FAULT);

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;

  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] result;
  logic [7:0] pc;
  logic       zero, carry, retire, busy, halted, fault;

  cpu_sequencer_if mem_bus ();

  cpu_sequencer #(.TIMEOUT(TO)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .mem    (mem_bus.master),
    .result (result),
    .pc     (pc),
    .zero   (zero),
    .carry  (carry),
    .retire (retire),
    .busy   (busy),
    .halted (halted),
    .fault  (fault)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [256];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int nret = 0;
  int c0;
  int r0;

  // Instruction-level reference state
  int m_pc, m_acc, m_zero, m_carry, m_halt;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (retire === 1'b1) nret <= nret + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rst_vals(input string tag);
    chk({tag, "_req"}, 32'(mem_bus.mem_req), 0);
    chk({tag, "_addr"}, 32'(mem_bus.mem_addr), 0);
    chk({tag, "_result"}, 32'(result), 0);
    chk({tag, "_pc"}, 32'(pc), 0);
    chk({tag, "_zero"}, 32'(zero), 1);
    chk({tag, "_carry"}, 32'(carry), 0);
    chk({tag, "_retire"}, 32'(retire), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_halted"}, 32'(halted), 0);
    chk({tag, "_fault"}, 32'(fault), 0);
  endtask

  // Architectural effect of one instruction (pc already advanced past it).
  task automatic model_exec(input logic [7:0] ins);
    int op, opd, s;
    op  = int'(ins[7:4]);
    opd = int'(ins[3:0]);
    case (op)
      1: begin m_acc = opd; m_zero = (m_acc == 0); end
      2: begin
        s = m_acc + opd;
        m_carry = (s > 15);
        m_acc = s % 16;
        m_zero = (m_acc == 0);
      end
      3: begin
        m_carry = (m_acc < opd);
        m_acc = (m_acc - opd + 16) % 16;
        m_zero = (m_acc == 0);
      end
      4: begin m_acc = m_acc & opd; m_carry = 0; m_zero = (m_acc == 0); end
      5: begin m_acc = m_acc | opd; m_carry = 0; m_zero = (m_acc == 0); end
      6: begin m_acc = m_acc ^ opd; m_carry = 0; m_zero = (m_acc == 0); end
      7: m_pc = opd;
      8: if (m_zero != 0) m_pc = opd;
      9: if (m_carry != 0) m_pc = opd;
      15: m_halt = 1;
      default: ;
    endcase
  endtask

  task automatic do_start();
    mem_bus.mem_ack = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_pc = 0; m_acc = 0; m_zero = 1; m_carry = 0; m_halt = 0;
    c0 = cyc;
    r0 = nret;
  endtask

  // Called at the negedge of the first FETCH cycle; returns at the negedge
  // after EXECUTE. Ack arrives after 'delay' idle FETCH cycles. ack/start
  // are toggled randomly in DECODE/EXECUTE, where they must be ignored.
  task automatic exec_instr(input int delay);
    logic [7:0] ins;
    chk("fetch_req", 32'(mem_bus.mem_req), 1);
    chk("fetch_addr", 32'(mem_bus.mem_addr), 32'(m_pc));
    for (int i = 0; i < delay; i++) begin
      mem_bus.mem_ack = 1'b0;
      mem_bus.mem_rdata = 8'($urandom);
      @(negedge clk);
      chk("wait_req", 32'(mem_bus.mem_req), 1);
      chk("wait_addr", 32'(mem_bus.mem_addr), 32'(m_pc));
    end
    ins = mem[m_pc];
    mem_bus.mem_ack = 1'b1;
    mem_bus.mem_rdata = ins;
    @(negedge clk);
    chk("dec_req", 32'(mem_bus.mem_req), 0);
    chk("dec_busy", 32'(busy), 1);
    chk("dec_retire", 32'(retire), 0);
    mem_bus.mem_ack = 1'($urandom);
    mem_bus.mem_rdata = 8'($urandom);
    start = 1'($urandom);
    @(negedge clk);
    chk("exe_retire", 32'(retire), 1);
    chk("exe_busy", 32'(busy), 1);
    mem_bus.mem_ack = 1'($urandom);
    start = 1'($urandom);
    m_pc = (m_pc + 1) % 256;
    model_exec(ins);
    @(negedge clk);
    mem_bus.mem_ack = 1'b0;
    start = 1'b0;
    chk("post_result", 32'(result), 32'(m_acc));
    chk("post_zero", 32'(zero), 32'(m_zero));
    chk("post_carry", 32'(carry), 32'(m_carry));
    chk("post_pc", 32'(pc), 32'(m_pc));
    chk("post_halted", 32'(halted), 32'(m_halt));
    chk("post_busy", 32'(busy), 32'(m_halt == 0));
    chk("post_retire", 32'(retire), 0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic clear_mem(input logic [7:0] fill);
    for (int i = 0; i < 256; i++) mem[i] = fill;
  endtask

  initial begin
    mem_bus.mem_ack = 1'b0;
    mem_bus.mem_rdata = 8'h00;
    clear_mem(8'h00);

    // Reset state, while held and after release with no start
    repeat (2) @(negedge clk);
    chk_rst_vals("rst_held");
    reset = 1'b0;
    @(negedge clk);
    chk_rst_vals("rst_idle");

    // LDI 1, ADD 5, HLT with ack every cycle
    mem[0] = 8'h11; mem[1] = 8'h25; mem[2] = 8'hF0;
    do_start();
    for (int i = 0; i < 3; i++) exec_instr(0);
    chk("p1_result", 32'(result), 6);
    chk("p1_halted", 32'(halted), 1);
    chk("p1_pc", 32'(pc), 3);
    chk("p1_cycles", 32'(cyc - c0), 9);
    chk("p1_retires", 32'(nret - r0), 3);

    // LDI F, ADD 1 (wrap to 0, carry), SUB 1 (borrow)
    clear_mem(8'h00);
    mem[0] = 8'h1F; mem[1] = 8'h21; mem[2] = 8'h31; mem[3] = 8'hF0;
    do_start();
    exec_instr(0);
    exec_instr(1);
    chk("add_result", 32'(result), 0);
    chk("add_carry", 32'(carry), 1);
    chk("add_zero", 32'(zero), 1);
    exec_instr(2);
    chk("sub_result", 32'(result), 15);
    chk("sub_carry", 32'(carry), 1);
    chk("sub_zero", 32'(zero), 0);
    exec_instr(0);

    // LDI 0, JZ 4, HLT at 4: fetch addresses 0,1,4
    clear_mem(8'h00);
    mem[0] = 8'h10; mem[1] = 8'h84; mem[4] = 8'hF0;
    do_start();
    chk("jz_addr0", 32'(mem_bus.mem_addr), 0);
    exec_instr(0);
    chk("jz_addr1", 32'(mem_bus.mem_addr), 1);
    exec_instr(0);
    chk("jz_addr4", 32'(mem_bus.mem_addr), 4);
    exec_instr(TO - 1);
    chk("jz_halted", 32'(halted), 1);
    chk("jz_pc", 32'(pc), 5);

    // 256 NOPs: pc wraps and fetching continues at 0
    clear_mem(8'h00);
    do_start();
    for (int i = 0; i < 256; i++) exec_instr(0);
    chk("wrap_pc", 32'(pc), 0);
    chk("wrap_req", 32'(mem_bus.mem_req), 1);
    exec_instr(0);
    pulse_reset();
    chk_rst_vals("wrap_rst");

    // Fetch timeout after one NOP, pc stays at 1
    do_start();
    exec_instr(0);
    for (int i = 0; i < TO; i++) begin
      chk("to_req", 32'(mem_bus.mem_req), 1);
      chk("to_fault", 32'(fault), 0);
      mem_bus.mem_ack = 1'b0;
      @(negedge clk);
    end
    chk("to_fault_set", 32'(fault), 1);
    chk("to_req_drop", 32'(mem_bus.mem_req), 0);
    chk("to_busy", 32'(busy), 0);
    chk("to_pc", 32'(pc), 1);
    mem_bus.mem_ack = 1'b1;
    @(negedge clk);
    mem_bus.mem_ack = 1'b0;
    chk("to_ack_ignored", 32'(fault), 1);
    chk("to_pc_hold", 32'(pc), 1);
    do_start();
    chk("restart_req", 32'(mem_bus.mem_req), 1);
    chk("restart_addr", 32'(mem_bus.mem_addr), 0);
    chk("restart_fault", 32'(fault), 0);

    // Asynchronous reset while mem_req is high (FETCH)
    #1 reset = 1'b1;
    #1 chk_rst_vals("rst_fetch");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_rst_vals("rst_fetch_idle");

    // Asynchronous reset during DECODE
    mem[0] = 8'h15;
    do_start();
    mem_bus.mem_ack = 1'b1;
    mem_bus.mem_rdata = mem[0];
    @(negedge clk);
    mem_bus.mem_ack = 1'b0;
    chk("rd_busy", 32'(busy), 1);
    chk("rd_pc", 32'(pc), 1);
    #1 reset = 1'b1;
    #1 chk_rst_vals("rst_decode");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_rst_vals("rst_decode_idle");

    // Random programs with random ack delays
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    do_start();
    for (int n = 0; n < 200; n++) begin
      if (m_halt != 0) do_start();
      if ($urandom_range(0, 7) == 0) exec_instr(TO - 1);
      else exec_instr(int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
